// File: rtl/scarv_cop_common.sv
// Shared definitions for the CPU-side COP instruction issue logic: FSM states,
// abort causes, result codes and channel widths.
package scarv_cop_common;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned REG_AW   = 5;
    localparam int unsigned RESULT_W = 3;

    localparam logic [RESULT_W-1:0] COP_RESULT_OK      = 3'b000;
    localparam logic [RESULT_W-1:0] COP_RESULT_TIMEOUT = 3'b111;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StRsp,
        StAbort
    } cop_issue_state_e;

    typedef enum logic {
        CauseFlush,
        CauseTimeout
    } abort_cause_e;

endpackage

// File: rtl/scarv_cpu_cop_issue_if.sv
// COP instruction channel between the CPU-side issuer (master) and the
// coprocessor (slave): request, abort and response handshakes.
interface scarv_cpu_cop_issue_if;
    import scarv_cop_common::*;

    logic                cpu_insn_req;
    logic                cop_insn_ack;
    logic                cpu_abort_req;
    logic [XLEN-1:0]     cpu_insn_enc;
    logic [XLEN-1:0]     cpu_rs1;
    logic                cop_insn_rsp;
    logic                cpu_insn_ack;
    logic                cop_wen;
    logic [REG_AW-1:0]   cop_waddr;
    logic [XLEN-1:0]     cop_wdata;
    logic [RESULT_W-1:0] cop_result;

    modport master (
        output cpu_insn_req,
        output cpu_abort_req,
        output cpu_insn_enc,
        output cpu_rs1,
        output cpu_insn_ack,
        input  cop_insn_ack,
        input  cop_insn_rsp,
        input  cop_wen,
        input  cop_waddr,
        input  cop_wdata,
        input  cop_result
    );

    modport slave (
        input  cpu_insn_req,
        input  cpu_abort_req,
        input  cpu_insn_enc,
        input  cpu_rs1,
        input  cpu_insn_ack,
        output cop_insn_ack,
        output cop_insn_rsp,
        output cop_wen,
        output cop_waddr,
        output cop_wdata,
        output cop_result
    );

endinterface

// File: rtl/scarv_cpu_cop_timeout.sv
// Saturating WAIT-cycle counter. expired_o flags the enabled cycle whose
// increment brings the count to TIMEOUT; TIMEOUT = 0 never expires.
module scarv_cpu_cop_timeout #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic g_clk,
    input  logic g_resetn,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CntW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (TIMEOUT != 0) && en_i && ((32'(cnt_q) + 32'd1) >= TIMEOUT);

endmodule

// File: rtl/scarv_cpu_cop_issue.sv
// CPU-side initiator for the COP instruction interface: issues one instruction,
// collects its response for GPR writeback, and aborts on flush or timeout.
module scarv_cpu_cop_issue
    import scarv_cop_common::*;
#(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                  g_clk,
    input  logic                  g_resetn,

    input  logic                  pipe_valid,
    output logic                  pipe_ready,
    input  logic [XLEN-1:0]       pipe_enc,
    input  logic [XLEN-1:0]       pipe_rs1,
    input  logic                  pipe_flush,

    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic                  wb_wen,
    output logic [REG_AW-1:0]     wb_waddr,
    output logic [XLEN-1:0]       wb_wdata,
    output logic [RESULT_W-1:0]   wb_result,

    scarv_cpu_cop_issue_if.master cop
);

    cop_issue_state_e    state_q;
    abort_cause_e        cause_q;
    logic                live_q;
    logic                req_q;
    logic                abort_q;
    logic [XLEN-1:0]     enc_q;
    logic [XLEN-1:0]     rs1_q;
    logic                wb_valid_q;
    logic                wb_wen_q;
    logic [REG_AW-1:0]   wb_waddr_q;
    logic [XLEN-1:0]     wb_wdata_q;
    logic [RESULT_W-1:0] wb_result_q;

    logic accept;
    logic rsp_ack;
    logic tmo_clr;
    logic tmo_en;
    logic tmo_expired;

    scarv_cpu_cop_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .g_clk     (g_clk),
        .g_resetn  (g_resetn),
        .clr_i     (tmo_clr),
        .en_i      (tmo_en),
        .expired_o (tmo_expired)
    );

    assign tmo_clr = (state_q == StReq) && cop.cop_insn_ack;
    assign tmo_en  = (state_q == StWait);

    // live_q keeps pipe_ready low while in reset and for the first cycle after.
    always_comb begin
        pipe_ready = 1'b0;
        rsp_ack    = 1'b0;
        case (state_q)
            StIdle:          pipe_ready = live_q;
            StRsp:           pipe_ready = wb_ready && !pipe_flush;
            StWait, StAbort: rsp_ack    = cop.cop_insn_rsp;
            default: ;
        endcase
    end

    assign accept = pipe_valid && pipe_ready;

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_q     <= StIdle;
            cause_q     <= CauseFlush;
            live_q      <= 1'b0;
            req_q       <= 1'b0;
            abort_q     <= 1'b0;
            enc_q       <= '0;
            rs1_q       <= '0;
            wb_valid_q  <= 1'b0;
            wb_wen_q    <= 1'b0;
            wb_waddr_q  <= '0;
            wb_wdata_q  <= '0;
            wb_result_q <= COP_RESULT_OK;
        end else begin
            live_q <= 1'b1;
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        enc_q   <= pipe_enc;
                        rs1_q   <= pipe_rs1;
                        req_q   <= 1'b1;
                        state_q <= StReq;
                    end
                end
                StReq: begin
                    if (cop.cop_insn_ack) begin
                        req_q <= 1'b0;
                        if (pipe_flush) begin
                            abort_q <= 1'b1;
                            cause_q <= CauseFlush;
                            state_q <= StAbort;
                        end else begin
                            state_q <= StWait;
                        end
                    end else if (pipe_flush) begin
                        req_q   <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                StWait: begin
                    if (cop.cop_insn_rsp) begin
                        // A flush racing the response still acks it, but drops the result.
                        if (pipe_flush) begin
                            state_q <= StIdle;
                        end else begin
                            wb_valid_q  <= 1'b1;
                            wb_wen_q    <= cop.cop_wen;
                            wb_waddr_q  <= cop.cop_waddr;
                            wb_wdata_q  <= cop.cop_wdata;
                            wb_result_q <= cop.cop_result;
                            state_q     <= StRsp;
                        end
                    end else if (pipe_flush || tmo_expired) begin
                        abort_q <= 1'b1;
                        cause_q <= pipe_flush ? CauseFlush : CauseTimeout;
                        state_q <= StAbort;
                    end
                end
                StAbort: begin
                    if (cop.cop_insn_rsp) begin
                        abort_q <= 1'b0;
                        if ((cause_q == CauseTimeout) && !pipe_flush) begin
                            wb_valid_q  <= 1'b1;
                            wb_wen_q    <= 1'b0;
                            wb_waddr_q  <= '0;
                            wb_wdata_q  <= '0;
                            wb_result_q <= COP_RESULT_TIMEOUT;
                            state_q     <= StRsp;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else if (pipe_flush) begin
                        cause_q <= CauseFlush;
                    end
                end
                StRsp: begin
                    if (pipe_flush) begin
                        wb_valid_q <= 1'b0;
                        state_q    <= StIdle;
                    end else if (wb_ready) begin
                        wb_valid_q <= 1'b0;
                        if (accept) begin
                            enc_q   <= pipe_enc;
                            rs1_q   <= pipe_rs1;
                            req_q   <= 1'b1;
                            state_q <= StReq;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign cop.cpu_insn_req  = req_q;
    assign cop.cpu_abort_req = abort_q;
    assign cop.cpu_insn_enc  = enc_q;
    assign cop.cpu_rs1       = rs1_q;
    assign cop.cpu_insn_ack  = rsp_ack;

    assign wb_valid  = wb_valid_q;
    assign wb_wen    = wb_wen_q;
    assign wb_waddr  = wb_waddr_q;
    assign wb_wdata  = wb_wdata_q;
    assign wb_result = wb_result_q;

endmodule

// File: tb/tb_scarv_cpu_cop_issue.sv
// Directed bench for scarv_cpu_cop_issue: inputs change on the falling edge,
// outputs are checked 1ns later, expected values are hand-derived constants.
module tb_scarv_cpu_cop_issue;

    logic        g_clk = 1'b0;
    logic        g_resetn;
    logic        pipe_valid;
    logic        pipe_ready;
    logic [31:0] pipe_enc;
    logic [31:0] pipe_rs1;
    logic        pipe_flush;
    logic        wb_valid;
    logic        wb_ready;
    logic        wb_wen;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic [2:0]  wb_result;

    int unsigned n_chk = 0;
    int unsigned n_bad = 0;

    scarv_cpu_cop_issue_if cop_if ();

    scarv_cpu_cop_issue #(
        .TIMEOUT (8)
    ) dut (
        .g_clk      (g_clk),
        .g_resetn   (g_resetn),
        .pipe_valid (pipe_valid),
        .pipe_ready (pipe_ready),
        .pipe_enc   (pipe_enc),
        .pipe_rs1   (pipe_rs1),
        .pipe_flush (pipe_flush),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_wen     (wb_wen),
        .wb_waddr   (wb_waddr),
        .wb_wdata   (wb_wdata),
        .wb_result  (wb_result),
        .cop        (cop_if)
    );

    always #5 g_clk = ~g_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Start a new cycle: wait for the falling edge, then clear one-shot inputs.
    task automatic next_cycle();
        @(negedge g_clk);
        pipe_valid          = 1'b0;
        pipe_flush          = 1'b0;
        wb_ready            = 1'b0;
        cop_if.cop_insn_ack = 1'b0;
        cop_if.cop_insn_rsp = 1'b0;
    endtask

    task automatic offer(input logic [31:0] enc, input logic [31:0] rs1);
        pipe_valid = 1'b1;
        pipe_enc   = enc;
        pipe_rs1   = rs1;
    endtask

    task automatic respond(input logic wen, input logic [4:0] waddr, input logic [31:0] wdata,
                           input logic [2:0] result);
        cop_if.cop_insn_rsp = 1'b1;
        cop_if.cop_wen      = wen;
        cop_if.cop_waddr    = waddr;
        cop_if.cop_wdata    = wdata;
        cop_if.cop_result   = result;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".req"},   {31'd0, cop_if.cpu_insn_req},  32'd0);
        chk({tag, ".abort"}, {31'd0, cop_if.cpu_abort_req}, 32'd0);
        chk({tag, ".ack"},   {31'd0, cop_if.cpu_insn_ack},  32'd0);
        chk({tag, ".enc"},   cop_if.cpu_insn_enc,           32'd0);
        chk({tag, ".rs1"},   cop_if.cpu_rs1,                32'd0);
        chk({tag, ".rdy"},   {31'd0, pipe_ready},           32'd0);
        chk({tag, ".wbv"},   {31'd0, wb_valid},             32'd0);
        chk({tag, ".wen"},   {31'd0, wb_wen},               32'd0);
        chk({tag, ".wa"},    {27'd0, wb_waddr},             32'd0);
        chk({tag, ".wd"},    wb_wdata,                      32'd0);
        chk({tag, ".res"},   {29'd0, wb_result},            32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        g_resetn = 1'b0;
        pipe_enc = '0;
        pipe_rs1 = '0;
        cop_if.cop_wen    = 1'b0;
        cop_if.cop_waddr  = '0;
        cop_if.cop_wdata  = '0;
        cop_if.cop_result = '0;
        next_cycle();
        next_cycle();
        #1 chk_all_zero("reset");
        g_resetn = 1'b1;
        next_cycle();
        next_cycle();
        #1 chk("idle.rdy", {31'd0, pipe_ready}, 32'd1);

        // Basic issue: accept(0), req/ack(1), rsp(2), wb_valid(3).
        offer(32'h0000_102B, 32'h1234_5678);
        #1 chk("b.c0.rdy", {31'd0, pipe_ready}, 32'd1);
        next_cycle();
        cop_if.cop_insn_ack = 1'b1;
        #1 chk("b.c1.req", {31'd0, cop_if.cpu_insn_req}, 32'd1);
        chk("b.c1.enc", cop_if.cpu_insn_enc, 32'h0000_102B);
        chk("b.c1.rs1", cop_if.cpu_rs1, 32'h1234_5678);
        next_cycle();
        respond(1'b1, 5'd5, 32'hDEAD_BEEF, 3'b000);
        #1 chk("b.c2.req", {31'd0, cop_if.cpu_insn_req}, 32'd0);
        chk("b.c2.ack", {31'd0, cop_if.cpu_insn_ack}, 32'd1);
        chk("b.c2.wbv", {31'd0, wb_valid}, 32'd0);
        next_cycle();
        #1 chk("b.c3.wbv", {31'd0, wb_valid}, 32'd1);
        chk("b.c3.ack", {31'd0, cop_if.cpu_insn_ack}, 32'd0);
        chk("b.c3.wen", {31'd0, wb_wen}, 32'd1);
        chk("b.c3.wa", {27'd0, wb_waddr}, 32'd5);
        chk("b.c3.wd", wb_wdata, 32'hDEAD_BEEF);
        chk("b.c3.res", {29'd0, wb_result}, 32'd0);
        wb_ready = 1'b1;
        next_cycle();
        #1 chk("b.c4.wbv", {31'd0, wb_valid}, 32'd0);
        chk("b.c4.rdy", {31'd0, pipe_ready}, 32'd1);

        // Ack stall: request and payload held for 5 REQ cycles despite input churn.
        offer(32'hA5A5_0001, 32'h0BAD_F00D);
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            pipe_enc = 32'hFFFF_0000 + 32'(i);
            pipe_rs1 = 32'h0000_FFFF - 32'(i);
            cop_if.cop_insn_ack = (i == 4);
            #1 chk("s.req", {31'd0, cop_if.cpu_insn_req}, 32'd1);
            chk("s.enc", cop_if.cpu_insn_enc, 32'hA5A5_0001);
            chk("s.rs1", cop_if.cpu_rs1, 32'h0BAD_F00D);
        end
        next_cycle();
        respond(1'b1, 5'd31, 32'h0000_0001, 3'b010);
        #1 chk("s.req.fall", {31'd0, cop_if.cpu_insn_req}, 32'd0);
        chk("s.ack", {31'd0, cop_if.cpu_insn_ack}, 32'd1);
        next_cycle();
        #1 chk("s.wbv", {31'd0, wb_valid}, 32'd1);
        chk("s.wa", {27'd0, wb_waddr}, 32'd31);
        chk("s.res", {29'd0, wb_result}, 32'd2);
        wb_ready = 1'b1;
        next_cycle();

        // Flush in REQ without ack: request dropped, no abort.
        offer(32'h0000_0033, 32'h0);
        next_cycle();
        pipe_flush = 1'b1;
        #1 chk("fr.req", {31'd0, cop_if.cpu_insn_req}, 32'd1);
        next_cycle();
        #1 chk("fr.req0", {31'd0, cop_if.cpu_insn_req}, 32'd0);
        chk("fr.abort", {31'd0, cop_if.cpu_abort_req}, 32'd0);
        chk("fr.rdy", {31'd0, pipe_ready}, 32'd1);

        // Flush two cycles after ack (A), response three cycles after flush.
        offer(32'h0000_202B, 32'h1);
        next_cycle();
        cop_if.cop_insn_ack = 1'b1;
        next_cycle();
        next_cycle();
        pipe_flush = 1'b1;
        #1 chk("fw.a2.abort", {31'd0, cop_if.cpu_abort_req}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            #1 chk("fw.abort", {31'd0, cop_if.cpu_abort_req}, 32'd1);
            chk("fw.ack0", {31'd0, cop_if.cpu_insn_ack}, 32'd0);
        end
        next_cycle();
        respond(1'b1, 5'd9, 32'h9999_9999, 3'b001);
        #1 chk("fw.rsp.abort", {31'd0, cop_if.cpu_abort_req}, 32'd1);
        chk("fw.rsp.ack", {31'd0, cop_if.cpu_insn_ack}, 32'd1);
        next_cycle();
        #1 chk("fw.end.abort", {31'd0, cop_if.cpu_abort_req}, 32'd0);
        chk("fw.end.ack", {31'd0, cop_if.cpu_insn_ack}, 32'd0);
        chk("fw.end.wbv", {31'd0, wb_valid}, 32'd0);
        chk("fw.end.rdy", {31'd0, pipe_ready}, 32'd1);

        // Timeout (TIMEOUT=8): silent for 8 WAIT cycles, abort at ack+9, rsp at ack+11.
        offer(32'h0000_302B, 32'h2);
        next_cycle();
        cop_if.cop_insn_ack = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            next_cycle();
            #1 chk("to.wait.abort", {31'd0, cop_if.cpu_abort_req}, 32'd0);
        end
        for (int i = 9; i <= 10; i++) begin
            next_cycle();
            #1 chk("to.abort", {31'd0, cop_if.cpu_abort_req}, 32'd1);
            chk("to.wbv0", {31'd0, wb_valid}, 32'd0);
        end
        next_cycle();
        respond(1'b1, 5'd7, 32'h0000_0055, 3'b011);
        #1 chk("to.rsp.ack", {31'd0, cop_if.cpu_insn_ack}, 32'd1);
        chk("to.rsp.abort", {31'd0, cop_if.cpu_abort_req}, 32'd1);
        next_cycle();
        #1 chk("to.wbv", {31'd0, wb_valid}, 32'd1);
        chk("to.wen", {31'd0, wb_wen}, 32'd0);
        chk("to.res", {29'd0, wb_result}, 32'd7);
        chk("to.abort.end", {31'd0, cop_if.cpu_abort_req}, 32'd0);
        wb_ready = 1'b1;
        next_cycle();

        // Backpressure with a second instruction pending, then back-to-back issue.
        offer(32'h0000_402B, 32'h3);
        next_cycle();
        cop_if.cop_insn_ack = 1'b1;
        next_cycle();
        respond(1'b1, 5'd12, 32'hCAFE_F00D, 3'b001);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            offer(32'h0000_502B, 32'h4);
            #1 chk("bp.wbv", {31'd0, wb_valid}, 32'd1);
            chk("bp.wa", {27'd0, wb_waddr}, 32'd12);
            chk("bp.wd", wb_wdata, 32'hCAFE_F00D);
            chk("bp.res", {29'd0, wb_result}, 32'd1);
            chk("bp.rdy", {31'd0, pipe_ready}, 32'd0);
        end
        next_cycle();
        offer(32'h0000_502B, 32'h4);
        wb_ready = 1'b1;
        #1 chk("bp.rdy1", {31'd0, pipe_ready}, 32'd1);
        chk("bp.req0", {31'd0, cop_if.cpu_insn_req}, 32'd0);
        next_cycle();
        #1 chk("bb.req", {31'd0, cop_if.cpu_insn_req}, 32'd1);
        chk("bb.enc", cop_if.cpu_insn_enc, 32'h0000_502B);
        chk("bb.wbv", {31'd0, wb_valid}, 32'd0);

        // Asynchronous reset between clock edges while in REQ.
        #2 g_resetn = 1'b0;
        #1 chk_all_zero("areset");
        next_cycle();
        g_resetn = 1'b1;
        next_cycle();
        next_cycle();
        #1 chk("post.rdy", {31'd0, pipe_ready}, 32'd1);
        chk("post.req", {31'd0, cop_if.cpu_insn_req}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/scarv_cpu_cop_issue.md
# scarv_cpu_cop_issue

CPU-side initiator for the COP instruction interface. It accepts one decoded coprocessor instruction at a time from the host CPU pipeline and drives the request channel `cpu_insn_req`/`cpu_insn_enc`/`cpu_rs1` into `scarv_cop_top`. It collects the COP response through the `cop_insn_rsp`/`cpu_insn_ack` handshake and hands the GPR writeback to the pipeline. It also generates `cpu_abort_req` on pipeline flush or on a response timeout.

## Interface
Parameters:
- `TIMEOUT`, 1024: maximum cycles in WAIT before a forced abort; 0 disables the timeout.

Ports:
- `g_clk` in 1: global clock.
- `g_resetn` in 1: reset, asynchronous, active-low.
- `pipe_valid` in 1: pipeline offers an instruction.
- `pipe_ready` out 1: block accepts the instruction.
- `pipe_enc` in 32: encoded instruction.
- `pipe_rs1` in 32: RS1 operand.
- `pipe_flush` in 1: kill the in-flight instruction.
- `wb_valid` out 1: writeback result available.
- `wb_ready` in 1: pipeline consumes the writeback.
- `wb_wen` out 1: GPR write enable.
- `wb_waddr` out 5: GPR destination address.
- `wb_wdata` out 32: GPR write data.
- `wb_result` out 3: COP result code.
- `cpu_insn_req` out 1: instruction request to the COP.
- `cop_insn_ack` in 1: COP accepts the request.
- `cpu_abort_req` out 1: abort the in-flight COP instruction.
- `cpu_insn_enc` out 32: encoding held for the COP.
- `cpu_rs1` out 32: RS1 held for the COP.
- `cop_insn_rsp` in 1: COP response valid.
- `cpu_insn_ack` out 1: response accepted.
- `cop_wen` in 1: COP writeback enable.
- `cop_waddr` in 5: COP writeback address.
- `cop_wdata` in 32: COP writeback data.
- `cop_result` in 3: COP result code.

## Operation
- FSM states: IDLE, REQ, WAIT, RSP, ABORT. Reset state is IDLE.
- Reset values: all outputs 0; `cpu_insn_enc` and `cpu_rs1` are 0.
- **IDLE:**
  - `pipe_ready` = 1.
  - On `pipe_valid`: register `pipe_enc` and `pipe_rs1` into `cpu_insn_enc`/`cpu_rs1` and go to REQ.
- **REQ:**
  - `cpu_insn_req` = 1.
  - `cpu_insn_enc` and `cpu_rs1` stay stable until the handshake completes.
  - If `cop_insn_ack` = 1: go to WAIT and clear the timeout counter.
  - If `pipe_flush` = 1 with ack low: drop the request and go to IDLE. No abort is needed because nothing was issued.
  - If `pipe_flush` = 1 with ack high in the same cycle: go to ABORT.
- **WAIT:**
  - Counter increments each cycle.
  - `cpu_insn_ack` = `cop_insn_rsp` (combinational).
  - On `cop_insn_rsp`: capture `cop_wen`/`cop_waddr`/`cop_wdata`/`cop_result` into the wb registers and go to RSP.
  - If `pipe_flush` = 1, or the counter reaches `TIMEOUT` (with `TIMEOUT` ≠ 0): go to ABORT and latch the abort cause (`flush` or `timeout`).
  - A response and a flush in the same cycle: the response is acked and discarded, and the block goes to IDLE.
- **ABORT:**
  - `cpu_abort_req` = 1 until `cop_insn_rsp` is seen.
  - `cpu_insn_ack` = `cop_insn_rsp`.
  - COP data is discarded.
  - Cause `timeout`: go to RSP with `wb_wen` = 0 and `wb_result` = `COP_RESULT_TIMEOUT`.
  - Cause `flush`: go to IDLE with no writeback.
  - `pipe_flush` while in ABORT with cause `timeout` converts the cause to `flush`.
- **RSP:**
  - `wb_valid` = 1. The wb outputs hold stable until `wb_ready`.
  - On `wb_ready`: go to IDLE.
  - `pipe_ready` = `wb_ready` in this state, allowing back-to-back issue straight into REQ.
  - `pipe_flush` clears `wb_valid` and returns to IDLE.
- Counter width: `$clog2(TIMEOUT+1)`. The counter saturates and never wraps.
- `cop_insn_ack` and `cop_insn_rsp` are ignored in any state other than those listed above.

## Timing
- `cpu_insn_req` rises the cycle after accept. It falls the cycle after the cycle in which `req` && `cop_insn_ack` are both high.
- Minimum latency with immediate ack and response:
  - accept at cycle 0;
  - `req`/`ack` at cycle 1;
  - `rsp`/`cpu_insn_ack` at cycle 2;
  - `wb_valid` at cycle 3.
- `cpu_insn_ack` is high for exactly one cycle per response.
- `cpu_abort_req` is asserted from the cycle after entry into ABORT until the response cycle inclusive.
- Timeout: entry into ABORT occurs on the cycle after the counter reaches `TIMEOUT`.
- Reset mid-operation returns to IDLE immediately, since reset is asynchronous. The COP is reset by the same `g_resetn`.

## Structure
- Shared package `scarv_cop_common`:
  - FSM state encoding;
  - result codes `COP_RESULT_OK` = 3'b000 and `COP_RESULT_TIMEOUT` = 3'b111;
  - interface width constants (32, 5, 3).
- One natural sub-module, `scarv_cpu_cop_timeout`: the saturating counter with clear, enable and `expired` output.

## Test plan
- **Basic issue:** enc 0x0000_102B, rs1 0x1234_5678, COP acks at once and responds a cycle later with wen = 1, waddr = 5, wdata = 0xDEAD_BEEF, result = 0. Required: `wb_valid` at cycle 3 with exactly those values; `cpu_insn_req` and `cpu_insn_ack` each high for one cycle.
- **Ack stall:** COP delays `cop_insn_ack` by 4 cycles. Required: `cpu_insn_req`, `cpu_insn_enc` and `cpu_rs1` stay stable for all 5 cycles.
- **Flush in WAIT:** flush 2 cycles after ack, COP responds 3 cycles later. Required: `cpu_abort_req` is high until the response; `cpu_insn_ack` pulses once; no `wb_valid`; block returns to IDLE.
- **Timeout:** with `TIMEOUT` = 8, the COP stays silent for 8 cycles after ack, then responds 2 cycles after abort. Required: `cpu_abort_req` rises at WAIT cycle 9; `wb_valid` is produced with `wb_result` = 3'b111 and `wb_wen` = 0.
- **Backpressure and back-to-back:** `wb_ready` is held low for 3 cycles with a second `pipe_valid` pending. Required: wb outputs stable for 3 cycles; the second request is accepted on the `wb_ready` cycle and `cpu_insn_req` rises the next cycle.
- **Async reset:** `g_resetn` is dropped mid-REQ, between clock edges. Required: `cpu_insn_req` = 0 immediately, and all outputs are 0.
